// File: rtl/periodic_sampler_n.sv
// Periodic sampler: counts down a programmable period, then captures the data field
// and a selectable address field, in continuous or one-shot mode.
module periodic_sampler_n #(
   parameter  int unsigned DW   = 8,
   parameter  int unsigned AW   = 4,
   parameter  int unsigned NSEL = 2,
   parameter  int unsigned CW   = 8,
   localparam int unsigned SW   = (NSEL > 1) ? $clog2(NSEL) : 1
) (
   input  logic                 clock,
   input  logic                 reset_,
   input  logic                 enable,
   input  logic                 mode,
   input  logic                 start,
   input  logic [CW-1:0]        period,
   input  logic [SW-1:0]        sel,
   input  logic [DW+NSEL*AW-1:0] d,
   output logic [DW-1:0]        z,
   output logic [AW-1:0]        a,
   output logic                 valid,
   output logic                 busy
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StCount  = 2'd1;
   localparam logic [1:0] StSample = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_d;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_d;
   logic [DW-1:0] r_z;
   logic [AW-1:0] r_a;
   logic          r_valid;
   logic          r_busy;
   logic          w_sample;
   logic          w_start_run;
   logic [CW-1:0] w_pe;
   logic [AW-1:0] w_addr;

   // Periods below 2 are raised to 2 so the count always exits at CNT==2 without wrapping.
   assign w_pe = (period < CW'(2)) ? CW'(2) : period;

   assign w_start_run = enable & (~mode | start);

   // Out-of-range selects never match a field and fall back to field 0.
   always_comb begin
      w_addr = d[DW +: AW];
      for (int unsigned k = 1; k < NSEL; k++) begin
         if (sel == SW'(k)) begin
            w_addr = d[DW + k*AW +: AW];
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_sample  = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_start_run) begin
               w_state_d = StCount;
               w_cnt_d   = w_pe;
            end
         end
         StCount: begin
            if (!enable) begin
               w_state_d = StIdle;
            end else if (r_cnt == CW'(2)) begin
               w_state_d = StSample;
            end else begin
               w_cnt_d = r_cnt - CW'(1);
            end
         end
         StSample: begin
            w_sample = 1'b1;
            if (enable && !mode) begin
               w_state_d = StCount;
               w_cnt_d   = w_pe;
            end else begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_busy  <= (w_state_d != StIdle);
      end
   end

   // Sample registers only load on the SAMPLE exit edge, so aborts leave them intact.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_z     <= '0;
         r_a     <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_sample;
         if (w_sample) begin
            r_z <= d[DW-1:0];
            r_a <= w_addr;
         end
      end
   end

   assign z     = r_z;
   assign a     = r_a;
   assign valid = r_valid;
   assign busy  = r_busy;

endmodule

// File: doc/periodic_sampler_n.md
PERIODIC_SAMPLER_N -- requirements
Module: periodic_sampler_n

Parameters
REQ-001 DW, default 8, width of the sampled data field and of output z.
REQ-002 AW, default 4, width of each address field and of output a.
REQ-003 NSEL, default 2, number of selectable address fields, minimum 2.
REQ-004 CW, default 8, width of the period input and of the internal down-counter.

Interface
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  1 = sampler runs; 0 = abort to IDLE.
REQ-008 mode  in  1  0 = continuous sampling; 1 = one-shot.
REQ-009 start  in  1  one-shot trigger; used only when mode=1.
REQ-010 period  in  CW  clock cycles per sample; values 0, 1 and 2 are treated as 2.
REQ-011 sel  in  clog2(NSEL)  selects which address field drives a.
REQ-012 d  in  DW+NSEL*AW  data word; d[DW-1:0] is data; address field k is d[DW+(k+1)*AW-1 : DW+k*AW].
REQ-013 z  out  DW  registered data sample.
REQ-014 a  out  AW  registered address field selected by sel.
REQ-015 valid  out  1  one-cycle strobe, high in the cycle z and a show a new sample.
REQ-016 busy  out  1  high while the FSM is in COUNT or SAMPLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, COUNT and SAMPLE, plus a CW-bit down-counter CNT.
- pe denotes the effective period, max(period, 2), latched only when CNT is loaded.

REQ-018 IDLE transitions:
- Enter COUNT with CNT<=pe when (enable & mode=0) or (enable & mode=1 & start).
- Otherwise stay in IDLE.

REQ-019 COUNT transitions:
- If enable=0, go to IDLE with no sample taken.
- Else if CNT==2, go to SAMPLE.
- Else stay in COUNT with CNT<=CNT-1.

REQ-020 SAMPLE actions:
- z<=d[DW-1:0].
- a<=address field sel; if sel>=NSEL, address field 0 is used.
- valid<=1 for exactly the following cycle.

REQ-021 SAMPLE transitions:
- Go to COUNT with CNT<=pe if enable & mode=0.
- Otherwise go to IDLE.

REQ-022 Sample latency and cadence:
- d and sel are captured at the clock edge that ends the SAMPLE state.
- In continuous mode, successive valid strobes are exactly pe cycles apart.
- The first strobe is pe+1 cycles after the edge that leaves IDLE.

REQ-023 z and a SHALL hold their values in every cycle except the one following SAMPLE, including across aborts.

REQ-024 Changes to period or mode in COUNT SHALL take effect only at the next CNT load or SAMPLE exit.

REQ-025 A start pulse arriving while busy=1 SHALL be ignored and not queued.

REQ-026 busy SHALL be a registered decode of the state: 1 in COUNT or SAMPLE, 0 in IDLE.

REQ-027 Arithmetic rules:
- CNT decrement is unsigned.
- CNT never wraps, because COUNT exits at 2.

Reset
REQ-028 When reset_ is low, the block SHALL immediately and asynchronously set: state=IDLE, CNT=0, z=0, a=0, valid=0, busy=0.

REQ-029 A reset asserted mid-COUNT or mid-SAMPLE SHALL discard any pending sample.

REQ-030 After reset_ rises, the block SHALL restart from IDLE and evaluate REQ-018 at the first clock edge.

Verification
REQ-031 Continuous default cadence:
- Stimulus: DW=8, AW=4, NSEL=2, mode=0, enable=1, period=10, d=16'hA5C3, sel=0.
- Response: valid pulses every 10 cycles; z=8'hC3, a=4'h5.

REQ-032 Address select and clamping:
- Stimulus: sel=1 with the REQ-031 setup.
- Response: a=4'hA.
- Stimulus: period=1.
- Response: valid every 2 cycles.

REQ-033 One-shot:
- Stimulus: mode=1, period=5, single start pulse.
- Response: exactly one valid, 6 cycles after start; then busy=0.
- Stimulus: second start while busy.
- Response: ignored.

REQ-034 Abort:
- Stimulus: drop enable 3 cycles into COUNT.
- Response: IDLE next cycle, no valid, z and a unchanged.

REQ-035 Async reset mid-count:
- Stimulus: pulse reset_ low between clock edges during COUNT.
- Response: z=0, a=0, busy=0 without waiting for a clock edge.
- After release: first valid pe+1 cycles after leaving IDLE.

REQ-036 Period change mid-count:
- Stimulus: change period 10 to 4 during COUNT.
- Response: the current interval stays 10; later intervals are 4.
